display_scheduler: RTL and testbench

Scheduler for the vending machine's four-digit multiplexed seven-segment display. It owns the digit-scan timing (prescaler plus 2-bit digit index), drives the one-hot digit enables, and decides frame by frame whether the shared segment path shows the drink-selection decode or the sensor-status decode. It sits between the board inputs and the existing digit decoders, drink/sensor segment decoders and segment muxes, replacing the free-running scan counter.

---
 rtl/disp_pkg.sv | 29 ++
 rtl/scan_prescaler.sv | 53 +++++
 rtl/display_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_display_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler.
//   state_t    : display schedule (drink view, held sensor view, fault view)
//   FAULT_CODE : sensor code that means "sensor fault"
//   AN_OFF     : all digit enables released (active-low)
//   an_decode  : digit index -> active-low one-hot digit enable
package disp_pkg;

  typedef enum logic [1:0] {
    DRINK  = 2'd0,
    SENSOR = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [2:0] FAULT_CODE = 3'b111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  function automatic logic [3:0] an_decode(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = 4'b1110;
      2'd1:    an = 4'b1101;
      2'd2:    an = 4'b1011;
      2'd3:    an = 4'b0111;
      default: an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-scan timing: prescaler, 2-bit digit index and frame pulse.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_scan_en       : count enable; scanning freezes while low
//   o_digit_idx     : current digit slot
//   o_frame_tick    : registered pulse, high for the cycle digit_idx wraps 3->0
//   o_slot_wrap     : high in the cycle whose closing edge advances digit_idx
//   o_frame_wrap    : high in the cycle whose closing edge wraps the frame
module scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_scan_en,
  output logic [1:0] o_digit_idx,
  output logic       o_frame_tick,
  output logic       o_slot_wrap,
  output logic       o_frame_wrap
);

  localparam int               CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_tick;

  // The wrap strobes are look-ahead flags so the top level can register its
  // outputs on the same edge that digit_idx moves.
  assign o_slot_wrap  = i_scan_en && (r_cnt == CNT_LAST);
  assign o_frame_wrap = o_slot_wrap && (r_idx == 2'd3);
  assign o_digit_idx  = r_idx;
  assign o_frame_tick = r_tick;

  // Prescaler, digit index and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_idx  <= 2'd0;
      r_tick <= 1'b0;
    end else if (o_slot_wrap) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_idx  <= r_idx + 2'd1;
      r_tick <= o_frame_wrap;
    end else if (i_scan_en) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Frame scheduler for the four-digit multiplexed seven-segment display.
// Decides per frame whether the shared segment path shows the drink decode
// or the sensor-status decode, and drives the digit enables.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   scan_en      : scan enable; display dark and timing frozen while low
//   drink_sel    : drink code (belongs to the drink decoder, not scheduled on)
//   sensor_st    : asynchronous sensor code, 3'b111 = fault
//   digit_idx    : digit slot for decoder selects
//   digit_an     : active-low one-hot digit enable (registered)
//   show_sensor  : segment mux select, 1 = sensor decode
//   blank        : segment blanking
//   frame_tick   : one-cycle pulse at each frame wrap
// Build option: define DISP_BLINK_EN to blink the display while in FAULT
// (blank toggles every BLINK_FRAMES frames); otherwise blank is tied low.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int ALARM_HOLD   = 200,
  parameter int BLINK_FRAMES = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [2:0] drink_sel,
  input  logic [2:0] sensor_st,
  output logic [1:0] digit_idx,
  output logic [3:0] digit_an,
  output logic       show_sensor,
  output logic       blank,
  output logic       frame_tick
);

  localparam int              HOLD_W    = $clog2(ALARM_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ALARM_HOLD);

  logic [1:0]        w_idx;
  logic [1:0]        w_idx_nxt;
  logic              w_slot_wrap;
  logic              w_frame_wrap;
  logic              w_tick;
  logic              w_chg;
  logic              w_fault;
  logic              w_blank_nxt;
  logic              w_unused;

  logic [2:0]        r_s1;
  logic [2:0]        r_s2;
  logic [2:0]        r_sp;
  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_show;
  logic [3:0]        r_an;

  // drink_sel is routed to the drink decoder elsewhere; the schedule ignores it.
  assign w_unused = ^drink_sel;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_scan_en    (scan_en),
    .o_digit_idx  (w_idx),
    .o_frame_tick (w_tick),
    .o_slot_wrap  (w_slot_wrap),
    .o_frame_wrap (w_frame_wrap)
  );

  assign w_idx_nxt = w_idx + {1'b0, w_slot_wrap};
  assign w_chg     = (r_s2 != r_sp);
  assign w_fault   = (r_s2 == FAULT_CODE);

  // Sensor synchronizer plus previous-value register for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 3'b000;
      r_s2 <= 3'b000;
      r_sp <= 3'b000;
    end else begin
      r_s1 <= sensor_st;
      r_s2 <= r_s1;
      r_sp <= r_s2;
    end
  end

  // Schedule FSM with hold counter; a sensor change outranks the frame
  // countdown so a fresh code always gets a full hold period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DRINK;
      r_hold  <= {HOLD_W{1'b0}};
      r_show  <= 1'b0;
    end else begin
      case (r_state)
        DRINK: begin
          if (w_fault) begin
            r_state <= FAULT;
            r_show  <= 1'b1;
          end else if (w_chg) begin
            r_state <= SENSOR;
            r_hold  <= HOLD_LOAD;
            r_show  <= 1'b1;
          end else begin
            r_show  <= 1'b0;
          end
        end
        SENSOR: begin
          if (w_fault) begin
            r_state <= FAULT;
            r_show  <= 1'b1;
          end else if (w_chg) begin
            r_hold  <= HOLD_LOAD;
            r_show  <= 1'b1;
          end else if (w_frame_wrap && (r_hold != {HOLD_W{1'b0}})) begin
            if (r_hold == HOLD_W'(1)) begin
              r_state <= DRINK;
              r_hold  <= {HOLD_W{1'b0}};
              r_show  <= 1'b0;
            end else begin
              r_hold  <= r_hold - HOLD_W'(1);
              r_show  <= 1'b1;
            end
          end else begin
            r_show  <= 1'b1;
          end
        end
        FAULT: begin
          if (!w_fault) begin
            r_state <= SENSOR;
            r_hold  <= HOLD_LOAD;
            r_show  <= 1'b1;
          end else begin
            r_show  <= 1'b1;
          end
        end
        default: begin
          r_state <= DRINK;
          r_hold  <= {HOLD_W{1'b0}};
          r_show  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DISP_BLINK_EN
  localparam int                BLINK_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] r_blink;
  logic [BLINK_W-1:0] w_blink_nxt;
  logic               r_blank;

  // Blink phase only advances while the fault persists; entering or leaving
  // FAULT restarts it dark-free.
  always_comb begin
    w_blink_nxt = {BLINK_W{1'b0}};
    w_blank_nxt = 1'b0;
    if ((r_state == FAULT) && w_fault) begin
      if (w_frame_wrap) begin
        if (r_blink == BLINK_LAST) begin
          w_blink_nxt = {BLINK_W{1'b0}};
          w_blank_nxt = ~r_blank;
        end else begin
          w_blink_nxt = r_blink + BLINK_W'(1);
          w_blank_nxt = r_blank;
        end
      end else begin
        w_blink_nxt = r_blink;
        w_blank_nxt = r_blank;
      end
    end else begin
      w_blink_nxt = {BLINK_W{1'b0}};
      w_blank_nxt = 1'b0;
    end
  end

  // Blink counter and blank register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= {BLINK_W{1'b0}};
      r_blank <= 1'b0;
    end else begin
      r_blink <= w_blink_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  assign blank = r_blank;
`else
  logic w_unused_blink;

  assign w_blank_nxt    = 1'b0;
  assign blank          = 1'b0;
  // BLINK_FRAMES only matters for the blinking build.
  assign w_unused_blink = (BLINK_FRAMES > 0);
`endif

  // Digit enables registered from next-cycle index and blank so they move on
  // the same edge as digit_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an <= AN_OFF;
    end else if (scan_en && !w_blank_nxt) begin
      r_an <= an_decode(w_idx_nxt);
    end else begin
      r_an <= AN_OFF;
    end
  end

  assign digit_idx   = w_idx;
  assign digit_an    = r_an;
  assign show_sensor = r_show;
  assign frame_tick  = w_tick;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler (SCAN_DIV=4, ALARM_HOLD=2,
// BLINK_FRAMES=2). Stimulus pushes hand-computed expectations tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_display_scheduler;

  localparam int SCAN_DIV     = 4;
  localparam int ALARM_HOLD   = 2;
  localparam int BLINK_FRAMES = 2;
`ifdef DISP_BLINK_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       scan_en;
  logic [2:0] drink_sel;
  logic [2:0] sensor_st;
  logic [1:0] digit_idx;
  logic [3:0] digit_an;
  logic       show_sensor;
  logic       blank;
  logic       frame_tick;

  display_scheduler #(
    .SCAN_DIV     (SCAN_DIV),
    .ALARM_HOLD   (ALARM_HOLD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .drink_sel   (drink_sel),
    .sensor_st   (sensor_st),
    .digit_idx   (digit_idx),
    .digit_an    (digit_an),
    .show_sensor (show_sensor),
    .blank       (blank),
    .frame_tick  (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] idx;
    logic [3:0] an;
    logic       show;
    logic       blk;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   c0 = 0;
  int   n_total = 0;
  int   n_pass = 0;
  bit   flush = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_at(input int n, input string nm, input logic [1:0] idx,
                        input logic [3:0] an, input logic show, input logic blk,
                        input logic tick);
    exp_t e;
    e.cyc  = c0 + n;
    e.name = nm;
    e.idx  = idx;
    e.an   = an;
    e.show = show;
    e.blk  = blk;
    e.tick = tick;
    exp_q.push_back(e);
  endtask

  task automatic step_to(input int n);
    repeat (c0 + n - cyc) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due at this negedge.
  always @(negedge clk) begin : mon
    exp_t e;
    while (exp_q.size() > 0 && (flush || exp_q[0].cyc <= cyc)) begin
      e = exp_q.pop_front();
      n_total++;
      if (e.cyc != cyc) begin
        $display("FAIL %s: check due at cycle %0d not reached in time (now %0d)",
                 e.name, e.cyc, cyc);
      end else if (digit_idx === e.idx && digit_an === e.an &&
                   show_sensor === e.show && blank === e.blk &&
                   frame_tick === e.tick) begin
        n_pass++;
      end else begin
        $display("FAIL %s @%0d: got idx=%0d an=%b show=%b blank=%b tick=%b, want idx=%0d an=%b show=%b blank=%b tick=%b",
                 e.name, cyc - c0, digit_idx, digit_an, show_sensor, blank,
                 frame_tick, e.idx, e.an, e.show, e.blk, e.tick);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    scan_en   = 1'b0;
    sensor_st = 3'b000;
    drink_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    c0 = cyc;
    exp_at(0, "reset", 2'd0, 4'b1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    scan_en   = 1'b1;
    drink_sel = 3'd3;

    // Plain scan after reset
    exp_at(1,  "scan_d0",    2'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    exp_at(4,  "scan_d1",    2'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    exp_at(7,  "scan_d1end", 2'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    exp_at(8,  "scan_d2",    2'd2, 4'b1011, 1'b0, 1'b0, 1'b0);
    exp_at(12, "scan_d3",    2'd3, 4'b0111, 1'b0, 1'b0, 1'b0);
    exp_at(15, "scan_d3end", 2'd3, 4'b0111, 1'b0, 1'b0, 1'b0);
    exp_at(16, "tick1",      2'd0, 4'b1110, 1'b0, 1'b0, 1'b1);
    exp_at(17, "tick1_off",  2'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    exp_at(32, "tick2",      2'd0, 4'b1110, 1'b0, 1'b0, 1'b1);

    // Sensor change 000->010: visible on 3rd edge, held two frames
    step_to(32);
    sensor_st = 3'b010;
    drink_sel = 3'd6;
    exp_at(34, "sens_lat2",  2'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    exp_at(35, "sens_lat3",  2'd0, 4'b1110, 1'b1, 1'b0, 1'b0);
    exp_at(48, "hold_f1",    2'd0, 4'b1110, 1'b1, 1'b0, 1'b1);
    exp_at(63, "hold_last",  2'd3, 4'b0111, 1'b1, 1'b0, 1'b0);
    exp_at(64, "hold_exit",  2'd0, 4'b1110, 1'b0, 1'b0, 1'b1);

    // Re-enter SENSOR, then a change coincident with the hold==1 frame wrap
    step_to(64);
    sensor_st = 3'b011;
    exp_at(67, "sens2_in",   2'd0, 4'b1110, 1'b1, 1'b0, 1'b0);
    exp_at(80, "sens2_f1",   2'd0, 4'b1110, 1'b1, 1'b0, 1'b1);
    step_to(93);
    sensor_st = 3'b010;
    drink_sel = 3'd1;
    exp_at(95,  "reload_pre", 2'd3, 4'b0111, 1'b1, 1'b0, 1'b0);
    exp_at(96,  "reload_win", 2'd0, 4'b1110, 1'b1, 1'b0, 1'b1);
    exp_at(127, "reload_end", 2'd3, 4'b0111, 1'b1, 1'b0, 1'b0);
    exp_at(128, "reload_out", 2'd0, 4'b1110, 1'b0, 1'b0, 1'b1);

    // scan_en low mid-frame in SENSOR
    step_to(128);
    sensor_st = 3'b011;
    exp_at(131, "sens3_in",  2'd0, 4'b1110, 1'b1, 1'b0, 1'b0);
    step_to(133);
    scan_en = 1'b0;
    exp_at(133, "pre_freeze", 2'd1, 4'b1101, 1'b1, 1'b0, 1'b0);
    exp_at(134, "freeze_a",   2'd1, 4'b1111, 1'b1, 1'b0, 1'b0);
    exp_at(150, "freeze_b",   2'd1, 4'b1111, 1'b1, 1'b0, 1'b0);
    exp_at(173, "freeze_c",   2'd1, 4'b1111, 1'b1, 1'b0, 1'b0);
    step_to(173);
    scan_en   = 1'b1;
    drink_sel = 3'd4;
    exp_at(174, "resume",     2'd1, 4'b1101, 1'b1, 1'b0, 1'b0);
    exp_at(176, "resume_d2",  2'd2, 4'b1011, 1'b1, 1'b0, 1'b0);
    exp_at(184, "resume_f1",  2'd0, 4'b1110, 1'b1, 1'b0, 1'b1);
    exp_at(199, "resume_end", 2'd3, 4'b0111, 1'b1, 1'b0, 1'b0);
    exp_at(200, "resume_out", 2'd0, 4'b1110, 1'b0, 1'b0, 1'b1);

    // Fault code
    step_to(200);
    sensor_st = 3'b111;
    exp_at(202, "fault_lat2", 2'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    exp_at(203, "fault_in",   2'd0, 4'b1110, 1'b1, 1'b0, 1'b0);
    exp_at(216, "fault_f1",   2'd0, 4'b1110, 1'b1, 1'b0, 1'b1);
    exp_at(231, "fault_f2p",  2'd3, 4'b0111, 1'b1, 1'b0, 1'b0);
    exp_at(232, "blink_on",   2'd0, B ? 4'b1111 : 4'b1110, 1'b1, B, 1'b1);
    exp_at(240, "blink_mid",  2'd2, B ? 4'b1111 : 4'b1011, 1'b1, B, 1'b0);
    exp_at(263, "blink_end",  2'd3, B ? 4'b1111 : 4'b0111, 1'b1, B, 1'b0);
    exp_at(264, "blink_off",  2'd0, 4'b1110, 1'b1, 1'b0, 1'b1);
    exp_at(296, "blink_on2",  2'd0, B ? 4'b1111 : 4'b1110, 1'b1, B, 1'b1);
    exp_at(299, "blink_on2b", 2'd0, B ? 4'b1111 : 4'b1110, 1'b1, B, 1'b0);

    // Asynchronous reset mid-frame in FAULT
    step_to(300);
    rst_n     = 1'b0;
    sensor_st = 3'b000;
    exp_at(300, "arst_now",  2'd0, 4'b1111, 1'b0, 1'b0, 1'b0);
    exp_at(301, "arst_hold", 2'd0, 4'b1111, 1'b0, 1'b0, 1'b0);
    exp_at(302, "arst_hold2", 2'd0, 4'b1111, 1'b0, 1'b0, 1'b0);
    step_to(302);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_at(303, "post_rst",   2'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    exp_at(305, "post_rst_b", 2'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    exp_at(306, "post_rst_c", 2'd1, 4'b1101, 1'b0, 1'b0, 1'b0);

    step_to(307);
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
